linebuffer_window9: RTL

- Streaming front end for the 9x9 logistic-regression inner-product stage.
- Accepts raster-order 7-bit pixels, one per accepted cycle, and keeps 8 line buffers plus a 9x9 window register.
- Presents the full 81-pixel window, row-major, to the combinational inner-product block.
- Pulses a valid for every window that lies fully inside the image.

---
 rtl/linebuffer_window9.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/linebuffer_window9.sv
// Raster-order line buffer and 9x9 sliding window feeding the inner-product stage.
// Eight column-indexed line buffers supply the upper rows; the incoming pixel completes the new right-hand column.
module linebuffer_window9 #(
  parameter int PIX_W = 7,
  parameter int K     = 9,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [PIX_W-1:0]       in_pix,
  output logic [K*K*PIX_W-1:0]   win_flat,
  output logic                   win_valid,
  output logic                   frame_done
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int NLB = K - 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);

  generate
    if (K != 9) begin : g_bad_k
      $error("linebuffer_window9: K must be 9");
    end
    if (IMG_W < K || IMG_H < K) begin : g_bad_img
      $error("linebuffer_window9: image must be at least K x K");
    end
  endgenerate

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] win_q [K][K];
  logic [PIX_W-1:0] win_d [K][K];

  logic             accept;
  logic [CW-1:0]    pos_c;
  logic [RW-1:0]    pos_r;
  logic             col_last;
  logic             row_last;

  logic [PIX_W-1:0] lb_mem [NLB][IMG_W];
  logic [PIX_W-1:0] lb_rd  [NLB];
  logic [PIX_W-1:0] col_in [K];

  // An in_sof pixel is forced to (0,0) so a mid-frame resync takes effect on this very accept.
  always_comb begin
    accept   = in_valid;
    pos_c    = in_sof ? '0 : col_q;
    pos_r    = in_sof ? '0 : row_q;
    col_last = (pos_c == COL_LAST);
    row_last = (pos_r == ROW_LAST);
    col_d    = col_q;
    row_d    = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : pos_r + RW'(1);
      end else begin
        col_d = pos_c + CW'(1);
        row_d = pos_r;
      end
    end
    win_valid_d  = accept && (pos_r >= ROW_KM1) && (pos_c >= COL_KM1);
    frame_done_d = accept && col_last && row_last;
  end

  always_comb begin
    for (int b = 0; b < NLB; b++) begin
      lb_rd[b] = lb_mem[b][pos_c];
    end
  end

  // Line buffers carry no reset: stale contents never reach a window flagged valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[0][pos_c] <= in_pix;
      for (int b = 1; b < NLB; b++) begin
        lb_mem[b][pos_c] <= lb_rd[b-1];
      end
    end
  end

  // New right column, top to bottom: oldest line buffer first, live pixel last.
  always_comb begin
    for (int i = 0; i < NLB; i++) begin
      col_in[i] = lb_rd[NLB-1-i];
    end
    col_in[K-1] = in_pix;
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][K-1] = col_in[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win_q[i][j] <= win_d[i][j];
        end
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < K; gi++) begin : g_row
      for (gj = 0; gj < K; gj++) begin : g_col
        assign win_flat[(gi*K+gj)*PIX_W +: PIX_W] = win_q[gi][gj];
      end
    end
  endgenerate

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule
